// File: rtl/booth_ctrl_pkg.sv
// Shared types and adder-operation codes for the radix-4 Booth multiplier control unit.
package booth_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [1:0] ACCU_PM  = 2'b00;
  localparam logic [1:0] ACCU_P2M = 2'b01;
  localparam logic [1:0] ACCU_MM  = 2'b10;
  localparam logic [1:0] ACCU_M2M = 2'b11;

endpackage

// File: rtl/booth_controller_decoder.sv
// Radix-4 Booth window decoder: {q(i+1), q(i), q(i-1)} -> adder operation and zero-op flag.
module booth_decoder
  import booth_ctrl_pkg::*;
(
  input  logic [2:0] control,
  output logic [1:0] accu,
  output logic       zero_op
);

  always_comb begin
    accu    = ACCU_PM;
    zero_op = 1'b0;
    case (control)
      3'b001, 3'b010: accu = ACCU_PM;
      3'b011:         accu = ACCU_P2M;
      3'b101, 3'b110: accu = ACCU_MM;
      3'b100:         accu = ACCU_M2M;
      default:        zero_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/booth_controller.sv
// Radix-4 Booth multiplier controller: IDLE -> INIT -> {ADD -> SHIFT} x tamano/2 -> FIN.
// Optional BOOTH_SKIP_ZERO_EN bypasses ADD whenever the upcoming Booth window is a zero op.
module booth_controller
  import booth_ctrl_pkg::*;
#(
  parameter int tamano = 8
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic [2:0] control,
  output logic [1:0] ACCU,
  output logic       enableM,
  output logic       enableSHI,
  output logic       enableLO,
  output logic       enableX,
  output logic       CARGA_SHI,
  output logic       CARGA_LO,
  output logic       CARGA_X,
  output logic       clearSHI,
  output logic       clearLO,
  output logic       clearX,
  output logic       BUSY,
  output logic       DONE
);

  localparam int ITER = tamano / 2;
  localparam int CW   = $clog2(ITER) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    dec_accu;
  logic          zero_op;

  booth_decoder u_decoder (
    .control (control),
    .accu    (dec_accu),
    .zero_op (zero_op)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (START) state_d = INIT;
      INIT: begin
        count_d = '0;
`ifdef BOOTH_SKIP_ZERO_EN
        state_d = zero_op ? SHIFT : ADD;
`else
        state_d = ADD;
`endif
      end
      ADD:  state_d = SHIFT;
      SHIFT: begin
        count_d = count_q + 1'b1;
        if (count_q == LAST_ITER) begin
          state_d = FIN;
        end else begin
`ifdef BOOTH_SKIP_ZERO_EN
          state_d = zero_op ? SHIFT : ADD;
`else
          state_d = ADD;
`endif
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ACCU      = ACCU_PM;
    enableM   = 1'b0;
    enableSHI = 1'b0;
    enableLO  = 1'b0;
    enableX   = 1'b0;
    CARGA_SHI = 1'b0;
    CARGA_LO  = 1'b0;
    CARGA_X   = 1'b0;
    clearSHI  = 1'b0;
    clearLO   = 1'b0;
    clearX    = 1'b0;
    BUSY      = (state_q != IDLE);
    DONE      = 1'b0;
    case (state_q)
      INIT: begin
        enableM  = 1'b1;
        enableLO = 1'b1;
        CARGA_LO = 1'b1;
        clearSHI = 1'b1;
        clearX   = 1'b1;
        CARGA_X  = 1'b1;
      end
      ADD: begin
        // A zero op leaves the high register untouched but still spends this cycle
        CARGA_SHI = 1'b1;
        enableSHI = ~zero_op;
        ACCU      = zero_op ? ACCU_PM : dec_accu;
      end
      SHIFT: begin
        enableSHI = 1'b1;
        enableLO  = 1'b1;
        enableX   = 1'b1;
      end
      FIN:     DONE = 1'b1;
      default: ;
    endcase
  end

endmodule
